segre_ifill_unit: RTL

- Instruction-line fill engine directly upstream of the fetch stage's instruction cache.
- On a fetch miss it issues one line request to main memory and collects the returned word beats into a full cache line.
- It then presents the line with a one-cycle ready pulse, which the fetch stage uses as its line input and memory-ready input.
- A taken-branch flush cancels delivery of an in-flight fill without breaking the memory handshake.

---
 rtl/segre_ifill_unit_if.sv | 27 ++
 rtl/segre_ifill_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/segre_ifill_unit_if.sv
// rtl/segre_ifill_unit_if.sv - memory-side line request/return bus of the fill engine
interface segre_ifill_unit_if #(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32
);
   logic                 mem_req_o;
   logic [ADDR_SIZE-1:0] mem_addr_o;
   logic                 mem_gnt_i;
   logic                 mem_rvalid_i;
   logic [WORD_SIZE-1:0] mem_rdata_i;

   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_gnt_i,
      input  mem_rvalid_i,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_gnt_i,
      output mem_rvalid_i,
      output mem_rdata_i
   );
endinterface

// File: rtl/segre_ifill_unit.sv
// rtl/segre_ifill_unit.sv - instruction-line fill engine between fetch miss and main memory
module segre_ifill_unit #(
   parameter int ADDR_SIZE             = 32,
   parameter int WORD_SIZE             = 32,
   parameter int CACHE_LINE_SIZE_BYTES = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  req_i,
   input  logic [ADDR_SIZE-1:0]                  addr_i,
   input  logic                                  flush_i,
   output logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] line_o,
   output logic                                  ready_o,
   output logic                                  busy_o,
   segre_ifill_unit_if.master                    mem_if
);
   localparam int NBEATS = CACHE_LINE_SIZE_BYTES * 8 / WORD_SIZE;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int LINE_W = CACHE_LINE_SIZE_BYTES * 8;

   localparam logic [ADDR_SIZE-1:0] OFFSET_MASK = ADDR_SIZE'(CACHE_LINE_SIZE_BYTES - 1);
   localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(NBEATS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_BEAT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ADDR_SIZE-1:0] addr_q,  addr_d;
   logic [BEAT_W-1:0]    beat_q,  beat_d;
   logic                 abort_q, abort_d;
   logic [LINE_W-1:0]    line_q,  line_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      abort_d = abort_q;
      line_d  = line_q;

      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            beat_d  = '0;
            // A redirect in the same cycle as the miss means the miss PC is already stale.
            if (req_i && !flush_i) begin
               addr_d  = addr_i & ~OFFSET_MASK;
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            if (flush_i) begin
               abort_d = 1'b1;
            end
            if (mem_if.mem_gnt_i) begin
               state_d = ST_BEAT;
            end
         end

         ST_BEAT: begin
            if (flush_i) begin
               abort_d = 1'b1;
            end
            // Beats are still absorbed after a flush so the memory transaction drains cleanly.
            if (mem_if.mem_rvalid_i) begin
               for (int b = 0; b < NBEATS; b++) begin
                  if (beat_q == BEAT_W'(b)) begin
                     line_d[b*WORD_SIZE +: WORD_SIZE] = mem_if.mem_rdata_i;
                  end
               end
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
         abort_q <= 1'b0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         abort_q <= abort_d;
         line_q  <= line_d;
      end
   end

   // flush_i is looked at directly so a redirect landing in the DONE cycle still suppresses the pulse.
   assign ready_o           = (state_q == ST_DONE) && !abort_q && !flush_i;
   assign busy_o            = (state_q != ST_IDLE);
   assign line_o            = line_q;
   assign mem_if.mem_req_o  = (state_q == ST_REQ);
   assign mem_if.mem_addr_o = addr_q;
endmodule
